// File: rtl/oled_pkg.sv
// oled_pkg: shared constants and types for the 128x64 OLED frame-buffer path.
//   PAGES/COLS : display geometry (8 pages of 8 pixel rows, 128 columns)
//   FB_DEPTH   : bytes per bank, AW : byte-address width
//   fb_addr_t  : linear byte address {page, col}
//   fb_state_t : swap controller FSM states
package oled_pkg;

    localparam int PAGES    = 8;
    localparam int COLS     = 128;
    localparam int FB_DEPTH = PAGES * COLS;
    localparam int AW       = $clog2(FB_DEPTH);

    typedef logic [AW-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        IDLE      = 2'd1,
        CLEAR     = 2'd2,
        SWAP_WAIT = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one frame-buffer bank, a DEPTH x 8 RAM with independent
// synchronous write and read ports.
//   clk      : clock
//   we_i     : write enable, waddr_i/wdata_i : write address/data
//   re_i     : read enable, raddr_i : read address
//   rdata_o  : registered read data, holds while re_i is low
module fb_bank
    import oled_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH
) (
    input  logic       clk,
    input  logic       we_i,
    input  fb_addr_t   waddr_i,
    input  logic [7:0] wdata_i,
    input  logic       re_i,
    input  fb_addr_t   raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array and its output register have no reset so the tools can
    // map them onto block RAM; the controller's INIT pass zeroes the contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffered frame-buffer controller.
//   clk, rst_n                         : clock, async active-low reset
//   wr_req/wr_page/wr_col/wr_data      : back-bank byte write request
//   wr_ack                             : write accepted this cycle (combinational)
//   clear_req                          : zero the back bank
//   swap_req                           : writer finished its frame
//   swap_ack                           : one-cycle pulse after a swap
//   disp_frame_end                     : display finished the last byte of a frame
//   rd_en/rd_page/rd_col/rd_data       : front-bank read port, 1-cycle latency
//   front_sel                          : index of the current front bank
//   busy                               : high during INIT or CLEAR
module fb_swap_ctrl #(
    parameter int PAGES = oled_pkg::PAGES,
    parameter int COLS  = oled_pkg::COLS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [$clog2(PAGES)-1:0] wr_page,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [7:0]               wr_data,
    output logic                     wr_ack,
    input  logic                     clear_req,
    input  logic                     swap_req,
    output logic                     swap_ack,
    input  logic                     disp_frame_end,
    input  logic                     rd_en,
    input  logic [$clog2(PAGES)-1:0] rd_page,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    output logic [7:0]               rd_data,
    output logic                     front_sel,
    output logic                     busy
);

    import oled_pkg::*;

    localparam fb_addr_t LAST = fb_addr_t'(PAGES * COLS - 1);

    fb_state_t  state_q;
    fb_addr_t   cnt_q, cnt_d;
    logic       front_sel_q, swap_ack_q, busy_q, pend_q;
    logic       rd_valid_q, rd_sel_q;

    logic       go_swap, back_we, we0, we1, rd_fire;
    fb_addr_t   waddr, raddr;
    logic [7:0] wdata, rdata0, rdata1;

    assign cnt_d = cnt_q + 1'b1;

    // NOTE: every signal gets a value on every path through this block, so
    // no latch can be inferred.
    always_comb begin
        go_swap = swap_req | pend_q;
        wr_ack  = (state_q == IDLE) && !clear_req && !go_swap && wr_req;
        // Back-bank writes come from the writer (IDLE) or the clear walk.
        back_we = (state_q == CLEAR) || wr_ack;
        // INIT zeroes both banks; otherwise only the bank that is not front.
        we0     = (state_q == INIT) || (back_we && front_sel_q);
        we1     = (state_q == INIT) || (back_we && !front_sel_q);
        waddr   = wr_ack ? {wr_page, wr_col} : cnt_q;
        wdata   = wr_ack ? wr_data : 8'h00;
        raddr   = {rd_page, rd_col};
        rd_fire = rd_en && (state_q != INIT);
    end

    fb_bank #(.DEPTH(PAGES * COLS)) u_bank0 (
        .clk     (clk),
        .we_i    (we0),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (rd_fire),
        .raddr_i (raddr),
        .rdata_o (rdata0)
    );

    fb_bank #(.DEPTH(PAGES * COLS)) u_bank1 (
        .clk     (clk),
        .we_i    (we1),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (rd_fire),
        .raddr_i (raddr),
        .rdata_o (rdata1)
    );

    // The bank select is captured with the read so a swap between the read
    // and the next one does not change the byte already presented. Until the
    // first read after INIT the output is held at zero.
    assign rd_data   = rd_valid_q ? (rd_sel_q ? rdata1 : rdata0) : 8'h00;
    assign front_sel = front_sel_q;
    assign swap_ack  = swap_ack_q;
    assign busy      = busy_q;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            busy_q      <= 1'b1;
            pend_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            if (rd_fire) begin
                rd_valid_q <= 1'b1;
                rd_sel_q   <= front_sel_q;
            end
            unique case (state_q)
                INIT, CLEAR: begin
                    if (state_q == CLEAR && swap_req) begin
                        pend_q <= 1'b1;
                    end
                    // Terminal count ends the walk; the counter never wraps.
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (go_swap) begin
                        // A frame end in this same cycle is deliberately ignored.
                        state_q <= SWAP_WAIT;
                        pend_q  <= 1'b0;
                    end
                end
                SWAP_WAIT: begin
                    if (disp_frame_end) begin
                        front_sel_q <= !front_sel_q;
                        swap_ack_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: directed scenarios plus randomized traffic for
// fb_swap_ctrl, checked each cycle against a behavioural model that tracks
// two byte arrays, the front index and remaining clear/init cycle counts.
module tb_fb_swap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [2:0] wr_page = '0;
    logic [6:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack;
    logic       clear_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       disp_frame_end = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_page = '0;
    logic [6:0] rd_col = '0;
    logic [7:0] rd_data;
    logic       front_sel;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_swap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req         (wr_req),
        .wr_page        (wr_page),
        .wr_col         (wr_col),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .clear_req      (clear_req),
        .swap_req       (swap_req),
        .swap_ack       (swap_ack),
        .disp_frame_end (disp_frame_end),
        .rd_en          (rd_en),
        .rd_page        (rd_page),
        .rd_col         (rd_col),
        .rd_data        (rd_data),
        .front_sel      (front_sel),
        .busy           (busy)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [2][1024];
    int         m_init_left;   // cycles of power-up clearing still to go
    int         m_clear_left;  // cycles of back-bank clearing still to go
    bit         m_frozen;      // back bank frozen waiting for a frame end
    bit         m_pending;     // swap requested while clearing
    int         m_front;
    logic [7:0] m_rd;
    bit         m_swap_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_idle();
        return m_init_left == 0 && m_clear_left == 0 && !m_frozen;
    endfunction

    function automatic bit m_ack();
        return m_idle() && !clear_req && !(swap_req || m_pending) && wr_req;
    endfunction

    function automatic void model_reset();
        m_init_left  = 1024;
        m_clear_left = 0;
        m_frozen     = 0;
        m_pending    = 0;
        m_front      = 0;
        m_rd         = 8'h00;
        m_swap_ack   = 0;
    endfunction

    function automatic void model_edge();
        int wa  = wr_page * 128 + wr_col;
        int ra  = rd_page * 128 + rd_col;
        bit ack = m_ack();
        m_swap_ack = 0;
        if (rd_en && m_init_left == 0) m_rd = m_mem[m_front][ra];
        if (m_init_left > 0) begin
            m_mem[0][1024 - m_init_left] = 8'h00;
            m_mem[1][1024 - m_init_left] = 8'h00;
            m_init_left--;
        end else if (m_clear_left > 0) begin
            m_mem[1 - m_front][1024 - m_clear_left] = 8'h00;
            if (swap_req) m_pending = 1;
            m_clear_left--;
        end else if (m_frozen) begin
            if (disp_frame_end) begin
                m_front    = 1 - m_front;
                m_swap_ack = 1;
                m_frozen   = 0;
            end
        end else if (clear_req) begin
            m_clear_left = 1024;
        end else if (swap_req || m_pending) begin
            m_frozen  = 1;
            m_pending = 0;
        end else if (ack) begin
            m_mem[1 - m_front][wa] = wr_data;
        end
    endfunction

    task automatic check_outputs();
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("busy", 32'(busy), 32'(m_init_left > 0 || m_clear_left > 0));
        check("swap_ack", 32'(swap_ack), 32'(m_swap_ack));
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic step();
        #1;
        check("wr_ack", 32'(wr_ack), 32'(m_ack()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic quiet();
        wr_req = 0; clear_req = 0; swap_req = 0; disp_frame_end = 0; rd_en = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_front"}, 32'(front_sel), 32'd0);
        check({tag, "_rd"}, 32'(rd_data), 32'h00);
        check({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
        check({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
    endtask

    // Steps until busy drops (bounded) and checks the busy length.
    task automatic run_busy(input string tag, input int already, input int expect_len);
        int n = already;
        for (int i = 0; i < 3000 && busy; i++) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(expect_len));
    endtask

    initial begin
        int acks;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1;

        // Power-up INIT: busy for exactly 1024 cycles, then zeros read back.
        check("busy_at_release", 32'(busy), 32'd1);
        run_busy("init_len", 0, 1024);
        rd_en = 1; rd_page = 3; rd_col = 5;
        step();
        rd_en = 0;
        check("rd_p3c5_zero", 32'(rd_data), 32'h00);
        check("front_after_init", 32'(front_sel), 32'd0);

        // Write 0xA5, swap, read it from the new front bank.
        wr_req = 1; wr_page = 2; wr_col = 10; wr_data = 8'hA5;
        #1 check("wr_ack_a5", 32'(wr_ack), 32'd1);
        step();
        wr_req = 0; swap_req = 1;
        step();
        swap_req = 0; disp_frame_end = 1;
        step();
        disp_frame_end = 0;
        check("swap_ack_pulse", 32'(swap_ack), 32'd1);
        check("front_is_1", 32'(front_sel), 32'd1);
        rd_en = 1; rd_page = 2; rd_col = 10;
        step();
        rd_en = 0;
        check("swap_ack_low", 32'(swap_ack), 32'd0);
        check("rd_a5", 32'(rd_data), 32'hA5);

        // Writer held off for 50 cycles of SWAP_WAIT, acked on first IDLE cycle.
        swap_req = 1;
        step();
        swap_req = 0;
        wr_req = 1; wr_page = 1; wr_col = 3; wr_data = 8'h3C;
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            #1 acks += int'(wr_ack);
            step();
        end
        check("no_ack_in_wait", 32'(acks), 32'd0);
        disp_frame_end = 1;
        step();
        disp_frame_end = 0;
        #1 check("ack_first_idle", 32'(wr_ack), 32'd1);
        step();
        wr_req = 0;

        // swap_req and frame end together: no swap until the next frame end.
        swap_req = 1; disp_frame_end = 1;
        step();
        quiet();
        check("same_cycle_no_swap", 32'(front_sel), 32'd0);
        repeat (199) step();
        disp_frame_end = 1;
        step();
        disp_frame_end = 0;
        check("late_swap", 32'(front_sel), 32'd1);

        // Clear, swap requested during it, frame end mid-clear ignored.
        clear_req = 1;
        step();
        clear_req = 0;
        repeat (9) step();
        swap_req = 1;
        step();
        swap_req = 0;
        repeat (489) step();
        disp_frame_end = 1;
        step();
        disp_frame_end = 0;
        check("no_swap_mid_clear", 32'(front_sel), 32'd1);
        run_busy("clear_len", 501, 1025);
        step();
        disp_frame_end = 1;
        step();
        disp_frame_end = 0;
        check("pending_swap", 32'(front_sel), 32'd0);
        acks = 0;
        for (int a = 0; a < 1024; a++) begin
            rd_en = 1; rd_page = 3'(a / 128); rd_col = 7'(a % 128);
            step();
            if (rd_data !== 8'h00) acks++;
        end
        rd_en = 0;
        check("front_all_zero", 32'(acks), 32'd0);

        // Reset in the middle of a clear.
        clear_req = 1;
        step();
        clear_req = 0;
        repeat (300) step();
        rst_n = 0;
        #1;
        check_reset_values("mid_clear_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        run_busy("reinit_len", 0, 1024);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 5000; i++) begin
            wr_req         = ($urandom_range(0, 1) == 1);
            wr_page        = 3'($urandom_range(0, 1));
            wr_col         = 7'($urandom_range(0, 15));
            wr_data        = 8'($urandom);
            rd_en          = ($urandom_range(0, 1) == 1);
            rd_page        = 3'($urandom_range(0, 1));
            rd_col         = 7'($urandom_range(0, 15));
            swap_req       = ($urandom_range(0, 15) == 0);
            disp_frame_end = ($urandom_range(0, 9) == 0);
            clear_req      = ($urandom_range(0, 1499) == 0);
            step();
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffered frame-buffer controller for the 128x64 OLED path. It holds two 1024-byte banks. One bank is the front bank, read byte-by-byte by the SPI display streamer. The other is the back bank, written by game logic. The block schedules bank clears, arbitrates back-bank writes, and swaps banks only at a display frame boundary, so a frame is never sent half-updated.

## Interface
Parameters:
- PAGES, 8, display pages (8 rows of pixels each)
- COLS, 128, columns per page
- Package `oled_pkg` derives FB_DEPTH = PAGES*COLS = 1024 and the address width AW = 10.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  writer request to store one byte in the back bank
- wr_page  in  3  write page
- wr_col  in  7  write column
- wr_data  in  8  write byte
- wr_ack  out  1  write accepted this cycle
- clear_req  in  1  request to zero the back bank
- swap_req  in  1  writer has finished its frame
- swap_ack  out  1  one-cycle pulse after a swap
- disp_frame_end  in  1  one-cycle pulse when the display finishes the last byte of a frame
- rd_en  in  1  display read strobe
- rd_page  in  3  read page
- rd_col  in  7  read column
- rd_data  out  8  front-bank byte, registered
- front_sel  out  1  index of the current front bank
- busy  out  1  high during INIT or CLEAR

## Operation
- Linear address = {page, col}. For example, page 7 col 127 = 1023.
- FSM states:
  - INIT: clears both banks.
  - IDLE: accepts writes.
  - CLEAR: zeroes the back bank.
  - SWAP_WAIT: back bank frozen until the frame boundary.
- After reset the FSM is in INIT. A 10-bit counter walks 0..1023 and writes 0x00 to both banks, one address per cycle. At count 1023 the FSM goes to IDLE.
- IDLE:
  - clear_req has priority: the FSM goes to CLEAR and the counter resets to 0.
  - Otherwise, if swap_req is high, the FSM goes to SWAP_WAIT.
  - Otherwise wr_ack = wr_req, and the byte is written to the back bank at that clock edge.
- CLEAR: writes 0x00 to back[counter] each cycle. At 1023 the FSM goes to IDLE. A swap_req seen during CLEAR sets a pending flag. That flag moves the FSM from IDLE to SWAP_WAIT on the first IDLE cycle.
- SWAP_WAIT: wr_ack = 0 and clear_req is ignored. On disp_frame_end, front_sel toggles at that edge, swap_ack pulses the next cycle, and the FSM goes to IDLE.
- wr_ack is combinational and is 0 in every state other than IDLE. A writer holds its request until it is acked.
- Reads always target the front bank and never conflict with writes. While rd_en is low, rd_data holds its value. During INIT, rd_data is forced to 0x00.

## Timing
- Reset values: state INIT, counter 0, front_sel 0, rd_data 0x00, swap_ack 0, busy 1, pending flag 0. Memory contents are not reset; INIT clears them.
- INIT lasts exactly 1024 cycles. busy falls on the cycle after address 1023 is written. CLEAR has the same duration.
- Read latency is 1 cycle: the address is sampled at edge N and rd_data is valid after edge N. This fits well inside the 8-cycle SPI byte slot.
- Write latency: the write is visible to a back-bank read (after a swap) on the next cycle.
- If swap_req and disp_frame_end are both high in the same IDLE cycle, no swap happens. The FSM enters SWAP_WAIT and waits for the next frame end.
- A disp_frame_end outside SWAP_WAIT is ignored.
- A swap_req held high after swap_ack starts a new SWAP_WAIT on the next IDLE cycle. Writers deassert swap_req on swap_ack.
- Asserting rst_n low mid-CLEAR or mid-SWAP_WAIT aborts immediately to the reset values; no swap occurs.
- The counter does not wrap past 1023; the terminal count ends the state.

## Structure
- `oled_pkg`: PAGES, COLS, FB_DEPTH, the `fb_addr_t` typedef (10-bit), and the `fb_state_t` enum {INIT, IDLE, CLEAR, SWAP_WAIT}.
- Sub-module `fb_bank`: 1024x8 RAM with a synchronous write port and a synchronous read port. It is instantiated twice.
- Top-level logic: bank-select muxing by front_sel, the FSM, the counter, and the pending flag.

## Test plan
- Reset, then idle: busy is high for exactly 1024 cycles. A read of page 3 col 5 returns 0x00. front_sel = 0.
- Write 0xA5 to page 2 col 10 (wr_ack = 1 in the same cycle). Then assert swap_req and pulse disp_frame_end. Expected: swap_ack one cycle later, front_sel = 1, and the read of page 2 col 10 returns 0xA5 after 1 cycle.
- Hold wr_req high during SWAP_WAIT for 50 cycles: wr_ack stays 0. After the swap, the write is acked in the first IDLE cycle.
- Pulse swap_req and disp_frame_end in the same cycle: front_sel does not change. A second disp_frame_end 200 cycles later performs the swap.
- Pulse clear_req, then swap_req 10 cycles later, then pulse disp_frame_end at cycle 500: no swap occurs. CLEAR completes at 1024 cycles, and the swap occurs on the next disp_frame_end. The new front bank reads all zeros.
- Assert rst_n low at CLEAR count 300: all outputs return to reset values asynchronously, and INIT restarts at counter 0.
